mdu_iter: RTL and testbench

- Iterative RV32M multiply/divide unit. Sits in the execute stage next to the combinational ALU.
- Takes the same operand-mux outputs (a, b) that feed the ALU.
- Its result joins the ALU result at the writeback mux.
- Uses a start/busy/done handshake, so the control FSM stalls while a multi-cycle M-extension op is in flight.

---
 rtl/mdu_pkg.sv | 41 ++++
 rtl/mdu_iter.sv | 197 +++++++++++++++++++
 tb/tb_mdu_iter.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg
// Shared definitions for the iterative RV32M multiply/divide unit and for the
// decoder that steers funct7=0000001 ops to it.
//   - MDU_* : RV32M funct3 encodings
//   - ST_*  : control state encoding of mdu_iter
//   - is_div / is_signed_a / is_signed_b : op-class predicates
// -----------------------------------------------------------------------------
package mdu_pkg;

  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // funct3[2] separates the divide/remainder group from the multiply group.
  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  // rs1 is interpreted as signed for mulh, mulhsu, div and rem.
  function automatic logic is_signed_a(input logic [2:0] op);
    return (op == MDU_MULH) || (op == MDU_MULHSU) ||
           (op == MDU_DIV)  || (op == MDU_REM);
  endfunction

  // rs2 is interpreted as signed for mulh, div and rem.
  function automatic logic is_signed_b(input logic [2:0] op);
    return (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// -----------------------------------------------------------------------------
// mdu_iter
// Iterative RV32M multiply/divide unit living beside the execute-stage ALU.
// Multiply is a 32-step shift-add, divide a 32-step restoring divide; both
// share one 65-bit shift register and one 33-bit adder/subtractor.
//
// Ports:
//   clk   in   rising-edge clock
//   rst   in   asynchronous active-high reset
//   start in   request a new op (only looked at in IDLE)
//   kill  in   synchronous abort, beats start
//   op    in   RV32M funct3
//   a, b  in   rs1 / rs2 operands, captured when start is accepted
//   busy  out  high in every state except IDLE
//   done  out  one-cycle pulse in DONE, y valid from then on
//   y     out  result register, held until the next completed op
// -----------------------------------------------------------------------------
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             kill,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]         state_q,  state_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [2:0]         op_q,     op_d;
  logic [2*WIDTH:0]   acc_q,    acc_d;
  logic [WIDTH-1:0]   mcand_q,  mcand_d;
  logic               negRes_q, negRes_d;
  logic               negRem_q, negRem_d;
  logic               spec_q,   spec_d;
  logic [WIDTH-1:0]   y_q,      y_d;

  logic               signA, signB, opIsDiv, opIsRem;
  logic [WIDTH-1:0]   absA, absB, specVal;
  logic               bZero, ovf;

  logic               sub;
  logic [WIDTH:0]     addX, addY, sum;
  logic [WIDTH:0]     remShift;
  logic [2*WIDTH:0]   mulStep, divStep;

  logic [2*WIDTH-1:0] prod, prodFix;
  logic [WIDTH-1:0]   quoFix, remFix, fixVal;

  // Operand conditioning on the incoming bus: strip the sign only where the op
  // treats that operand as signed, and work out the special-case result so it
  // can be parked in the shift register and skip the iterations entirely.
  always_comb begin
    opIsDiv = is_div(op);
    opIsRem = op[1];
    signA   = is_signed_a(op) & a[WIDTH-1];
    signB   = is_signed_b(op) & b[WIDTH-1];
    absA    = signA ? -a : a;
    absB    = signB ? -b : b;
    bZero   = (b == '0);
    ovf     = is_signed_a(op) && (a == MIN_NEG) && (b == '1);
    if (bZero) begin
      specVal = opIsRem ? a : '1;
    end else begin
      specVal = opIsRem ? '0 : MIN_NEG;
    end
  end

  // The one shared 33-bit adder. Multiply adds the multiplicand to the upper
  // product half; divide subtracts the divisor from the left-shifted remainder.
  // The remainder is always below the divisor, so its bit 32 is never needed
  // and the shifted value fits in 33 bits, with sum[WIDTH] acting as the sign.
  always_comb begin
    sub      = is_div(op_q);
    remShift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    addX     = sub ? remShift : acc_q[2*WIDTH:WIDTH];
    addY     = {1'b0, mcand_q} ^ {(WIDTH+1){sub}};
    sum      = addX + addY + {{WIDTH{1'b0}}, sub};
    mulStep  = {1'b0, (acc_q[0] ? sum : acc_q[2*WIDTH:WIDTH]), acc_q[WIDTH-1:1]};
    divStep  = {(sum[WIDTH] ? remShift : sum), acc_q[WIDTH-2:0], ~sum[WIDTH]};
  end

  // Final sign correction and result selection, loaded into y in FIX.
  always_comb begin
    prod    = acc_q[2*WIDTH-1:0];
    prodFix = negRes_q ? -prod : prod;
    quoFix  = negRes_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    remFix  = negRem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    if (spec_q) begin
      fixVal = acc_q[WIDTH-1:0];
    end else if (is_div(op_q)) begin
      fixVal = op_q[1] ? remFix : quoFix;
    end else if (op_q == MDU_MUL) begin
      fixVal = prodFix[WIDTH-1:0];
    end else begin
      fixVal = prodFix[2*WIDTH-1:WIDTH];
    end
  end

  // Control: IDLE captures, CALC iterates 32 times, FIX corrects and loads y,
  // DONE pulses done for one cycle. kill overrides everything and leaves y.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    negRes_d = negRes_q;
    negRem_d = negRem_q;
    spec_d   = spec_q;
    y_d      = y_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d     = op;
          mcand_d  = opIsDiv ? absB : absA;
          negRes_d = signA ^ signB;
          negRem_d = signA;
          cnt_d    = '0;
          if (opIsDiv && (bZero || ovf)) begin
            acc_d   = {{(WIDTH+1){1'b0}}, specVal};
            spec_d  = 1'b1;
            state_d = ST_FIX;
          end else begin
            acc_d   = {{(WIDTH+1){1'b0}}, (opIsDiv ? absA : absB)};
            spec_d  = 1'b0;
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        acc_d = sub ? divStep : mulStep;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        y_d     = fixVal;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (kill) begin
      state_d = ST_IDLE;
      y_d     = y_q;
    end
  end

  // State registers; reset discards any op in flight and clears the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      negRes_q <= 1'b0;
      negRem_q <= 1'b0;
      spec_q   <= 1'b0;
      y_q      <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      negRes_q <= negRes_d;
      negRem_q <= negRem_d;
      spec_q   <= spec_d;
      y_q      <= y_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);
  assign y    = y_q;

endmodule

// File: tb/tb_mdu_iter.sv
// -----------------------------------------------------------------------------
// tb_mdu_iter
// Directed self-checking bench for mdu_iter. Each test task drives its own
// scenario and compares against hand-computed results.
// -----------------------------------------------------------------------------
module tb_mdu_iter;
  import mdu_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic        kill;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] y;

  int checks = 0;
  int errors = 0;

  mdu_iter #(.WIDTH(32), .CNT_W(6)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .kill  (kill),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .y     (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one op and measures it: edges from the start-sampling edge to done,
  // whether busy stayed high meanwhile, and done/busy one edge after done.
  task automatic issue_op(input logic [2:0] opv, input logic [31:0] av,
                          input logic [31:0] bv, output int lat,
                          output logic [31:0] yv, output bit busyOk,
                          output logic doneAfter, output logic busyAfter);
    @(negedge clk);
    start = 1'b1; op = opv; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    busyOk = 1'b1;
    while (!done && lat < 60) begin
      if (!busy) busyOk = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (!busy) busyOk = 1'b0;
    yv = y;
    @(posedge clk); #1;
    doneAfter = done;
    busyAfter = busy;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; kill = 1'b0; op = '0; a = '0; b = '0;
    #12;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", done); end
    checks++;
    if (y !== 32'h0) begin errors++; $display("[TB] FAIL reset_y got %h want 00000000", y); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_mul();
    int lat; logic [31:0] yv; bit bok; logic dA, bA;
    issue_op(MDU_MUL, 32'd7, 32'hFFFFFFFD, lat, yv, bok, dA, bA);
    checks++;
    if (yv !== 32'hFFFFFFEB) begin errors++; $display("[TB] FAIL mul_y got %h want ffffffeb", yv); end
    checks++;
    if (lat != 34) begin errors++; $display("[TB] FAIL mul_latency got %0d want 34", lat); end
    checks++;
    if (!bok) begin errors++; $display("[TB] FAIL mul_busy got low want high during op"); end
    checks++;
    if (dA !== 1'b0 || bA !== 1'b0) begin
      errors++; $display("[TB] FAIL mul_after_done got done=%b busy=%b want 0 0", dA, bA);
    end
  endtask

  task automatic test_mul_high();
    int lat; logic [31:0] yv; bit bok; logic dA, bA;
    issue_op(MDU_MULH, 32'h80000000, 32'h80000000, lat, yv, bok, dA, bA);
    checks++;
    if (yv !== 32'h40000000) begin errors++; $display("[TB] FAIL mulh_y got %h want 40000000", yv); end
    issue_op(MDU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, yv, bok, dA, bA);
    checks++;
    if (yv !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL mulhsu_y got %h want ffffffff", yv); end
    issue_op(MDU_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, yv, bok, dA, bA);
    checks++;
    if (yv !== 32'hFFFFFFFE) begin errors++; $display("[TB] FAIL mulhu_y got %h want fffffffe", yv); end
    checks++;
    if (lat != 34) begin errors++; $display("[TB] FAIL mulhu_latency got %0d want 34", lat); end
  endtask

  task automatic test_div();
    int lat; logic [31:0] yv; bit bok; logic dA, bA;
    issue_op(MDU_DIV, 32'hFFFFFFF9, 32'd2, lat, yv, bok, dA, bA);
    checks++;
    if (yv !== 32'hFFFFFFFD) begin errors++; $display("[TB] FAIL div_y got %h want fffffffd", yv); end
    checks++;
    if (lat != 34) begin errors++; $display("[TB] FAIL div_latency got %0d want 34", lat); end
    issue_op(MDU_REM, 32'hFFFFFFF9, 32'd2, lat, yv, bok, dA, bA);
    checks++;
    if (yv !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL rem_y got %h want ffffffff", yv); end
    issue_op(MDU_DIVU, 32'd100, 32'd7, lat, yv, bok, dA, bA);
    checks++;
    if (yv !== 32'd14) begin errors++; $display("[TB] FAIL divu_y got %h want 0000000e", yv); end
    issue_op(MDU_REMU, 32'd100, 32'd7, lat, yv, bok, dA, bA);
    checks++;
    if (yv !== 32'd2) begin errors++; $display("[TB] FAIL remu_y got %h want 00000002", yv); end
  endtask

  task automatic test_special();
    int lat; logic [31:0] yv; bit bok; logic dA, bA;
    issue_op(MDU_DIVU, 32'd5, 32'd0, lat, yv, bok, dA, bA);
    checks++;
    if (yv !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL divu_by0_y got %h want ffffffff", yv); end
    checks++;
    if (lat != 2) begin errors++; $display("[TB] FAIL divu_by0_latency got %0d want 2", lat); end
    issue_op(MDU_REM, 32'd5, 32'd0, lat, yv, bok, dA, bA);
    checks++;
    if (yv !== 32'd5) begin errors++; $display("[TB] FAIL rem_by0_y got %h want 00000005", yv); end
    checks++;
    if (lat != 2) begin errors++; $display("[TB] FAIL rem_by0_latency got %0d want 2", lat); end
    issue_op(MDU_DIV, 32'h80000000, 32'hFFFFFFFF, lat, yv, bok, dA, bA);
    checks++;
    if (yv !== 32'h80000000) begin errors++; $display("[TB] FAIL div_ovf_y got %h want 80000000", yv); end
    checks++;
    if (lat != 2) begin errors++; $display("[TB] FAIL div_ovf_latency got %0d want 2", lat); end
    issue_op(MDU_REM, 32'h80000000, 32'hFFFFFFFF, lat, yv, bok, dA, bA);
    checks++;
    if (yv !== 32'h0) begin errors++; $display("[TB] FAIL rem_ovf_y got %h want 00000000", yv); end
    checks++;
    if (lat != 2) begin errors++; $display("[TB] FAIL rem_ovf_latency got %0d want 2", lat); end
  endtask

  task automatic test_kill();
    int lat; logic [31:0] yv; bit bok; logic dA, bA;
    bit sawDone;
    issue_op(MDU_DIVU, 32'd100, 32'd7, lat, yv, bok, dA, bA);
    @(negedge clk);
    start = 1'b1; op = MDU_DIV; a = 32'hFFFFFFF9; b = 32'd2;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL kill_busy got %b want 0", busy); end
    checks++;
    if (y !== 32'd14) begin errors++; $display("[TB] FAIL kill_y got %h want 0000000e", y); end
    sawDone = 1'b0;
    repeat (40) begin
      if (done) sawDone = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (sawDone) begin errors++; $display("[TB] FAIL kill_no_done got done pulse want none"); end
  endtask

  task automatic test_async_reset();
    int lat; logic [31:0] yv; bit bok; logic dA, bA;
    @(negedge clk);
    start = 1'b1; op = MDU_DIV; a = 32'hFFFFFFF9; b = 32'd2;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL arst_busy got %b want 0", busy); end
    checks++;
    if (y !== 32'h0) begin errors++; $display("[TB] FAIL arst_y got %h want 00000000", y); end
    @(negedge clk);
    rst = 1'b0;
    issue_op(MDU_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, yv, bok, dA, bA);
    checks++;
    if (yv !== 32'hFFFFFFFE) begin errors++; $display("[TB] FAIL arst_recover_y got %h want fffffffe", yv); end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    start = 1'b1; op = MDU_MUL; a = 32'd3; b = 32'd5;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL held_accept_busy got %b want 1", busy); end
    a = 32'd2; b = 32'd9;
    lat = 1;
    while (!done && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat != 34) begin errors++; $display("[TB] FAIL held_latency got %0d want 34", lat); end
    checks++;
    if (y !== 32'd15) begin errors++; $display("[TB] FAIL held_y got %h want 0000000f", y); end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL held_idle_after_done got busy=%b want 0", busy); end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL held_reaccept got busy=%b want 1", busy); end
    start = 1'b0;
    lat = 1;
    while (!done && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (y !== 32'd18) begin errors++; $display("[TB] FAIL held_second_y got %h want 00000012", y); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mul_high();
    test_div();
    test_special();
    test_kill();
    test_async_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
